// File: rtl/mmio_button_reader_if.sv
// CPU register bus between tinyrv32 and the button reader.
// master: CPU side (addr/data/strobes), slave: peripheral side (rdata/rvalid).
interface mmio_button_reader_if;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic        wea;
  logic        rea;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output m_addr,
    output m_data,
    output wea,
    output rea,
    input  rdata,
    input  rvalid
  );

  modport slave (
    input  m_addr,
    input  m_data,
    input  wea,
    input  rea,
    output rdata,
    output rvalid
  );
endinterface

// File: rtl/mmio_button_reader.sv
// Button reader: 2-flop sync, per-bit debounce, sticky rise events,
// LEVEL/EVENT(W1C)/MASK registers on a 16-byte MMIO window.
// Ports: clk, rst (sync, active-high), bus (slave), btn[N_IN-1:0],
// irq (only when BTN_IRQ_EN is defined; adds MASK at offset 0xC).
module mmio_button_reader #(
  parameter int          N_IN            = 8,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR       = 32'h2020
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_button_reader_if.slave  bus,
  input  logic [N_IN-1:0]      btn
`ifdef BTN_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0] s1_q, s1_d;
  logic [N_IN-1:0] s2_q, s2_d;
  logic [N_IN-1:0] stable_q, stable_d;
  logic [N_IN-1:0] event_q, event_d;
  logic [CW-1:0]   cnt_q [N_IN];
  logic [CW-1:0]   cnt_d [N_IN];
  logic [31:0]     rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;

  logic            hit;
  logic [1:0]      off;
  logic            wr;
  logic            rd;
  logic [N_IN-1:0] clr;
  logic [N_IN-1:0] rise;
  logic [31:0]     rd_val;
  logic            unused_bits;

`ifdef BTN_IRQ_EN
  logic [N_IN-1:0] mask_q, mask_d;
  logic            irq_q, irq_d;
`endif

  assign hit = bus.m_addr[31:4] == BASE_ADDR[31:4];
  assign off = bus.m_addr[3:2];
  assign wr  = bus.wea && hit;
  assign rd  = bus.rea && hit;

  assign unused_bits = ^{bus.m_addr[1:0], bus.m_data};

  always_comb begin
    s1_d     = btn;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < N_IN; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    // A rise landing on the same edge as its W1C must survive.
    clr = '0;
    if (wr && off == 2'd1) clr = bus.m_data[N_IN-1:0];
    rise    = stable_d & ~stable_q;
    event_d = (event_q & ~clr) | rise;

`ifdef BTN_IRQ_EN
    mask_d = mask_q;
    if (wr && off == 2'd3) mask_d = bus.m_data[N_IN-1:0];
    irq_d = |(event_d & mask_d);
`endif

    // Reads see pre-edge state, so a read+W1C returns pre-clear.
    case (off)
      2'd0:    rd_val = 32'(stable_q);
      2'd1:    rd_val = 32'(event_q);
`ifdef BTN_IRQ_EN
      2'd3:    rd_val = 32'(mask_q);
`endif
      default: rd_val = '0;
    endcase

    rvalid_d = rd;
    rdata_d  = rd ? rd_val : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      event_q  <= '0;
      cnt_q    <= '{default: '0};
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef BTN_IRQ_EN
      mask_q   <= '0;
      irq_q    <= 1'b0;
`endif
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      event_q  <= event_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
`ifdef BTN_IRQ_EN
      mask_q   <= mask_d;
      irq_q    <= irq_d;
`endif
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
`ifdef BTN_IRQ_EN
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_mmio_button_reader.sv
// Scoreboard bench for mmio_button_reader (DEBOUNCE_CYCLES=4).
// Reads push expected rdata; a negedge monitor pops on rvalid.
module tb_mmio_button_reader;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn;
`ifdef BTN_IRQ_EN
  logic       irq;
`endif

  always #5 clk = ~clk;

  mmio_button_reader_if bus();

  mmio_button_reader #(
    .N_IN(8),
    .DEBOUNCE_CYCLES(4),
    .BASE_ADDR(32'h2020)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .btn(btn)
`ifdef BTN_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got rdata %h want none",
                 bus.rdata);
      end else begin
        check("rdata", bus.rdata, exp_q.pop_front());
      end
    end
  end

  // Drive one cycle starting at a negedge; returns at the next negedge.
  task automatic cyc(input logic r, input logic [31:0] a,
                     input logic re, input logic we,
                     input logic [31:0] d);
    rst        = r;
    bus.m_addr = a;
    bus.rea    = re;
    bus.wea    = we;
    bus.m_data = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    cyc(1'b0, a, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, a, 1'b0, 1'b1, d);
  endtask

  task automatic rdwr(input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] e);
    exp_q.push_back(e);
    cyc(1'b0, a, 1'b1, 1'b1, d);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    btn        = '0;
    rst        = 1'b1;
    bus.m_addr = '0;
    bus.m_data = '0;
    bus.rea    = 1'b0;
    bus.wea    = 1'b0;
    @(negedge clk);

    // Reset and empty reads
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
`ifdef BTN_IRQ_EN
    check("rst_irq", 32'(irq), 32'h0);
`endif
    rd(32'h2020, 32'h0);
    rd(32'h2024, 32'h0);
    idle(1);
    check("pulse_end", 32'(bus.rvalid), 32'h0);

    // btn[2] rise: s1 on edge 0, stable on edge 5
    btn[2] = 1'b1;
    idle(5);
    rd(32'h2020, 32'h0);
    rd(32'h2020, 32'h4);
    rd(32'h2024, 32'h4);
    idle(1);

    // 3-cycle glitch on btn[0] rejected
    btn[0] = 1'b1;
    idle(3);
    btn[0] = 1'b0;
    idle(10);
    rd(32'h2020, 32'h4);
    rd(32'h2024, 32'h4);

    // Build event = 5, then drop btn[0]
    btn[0] = 1'b1;
    idle(8);
    rd(32'h2024, 32'h5);
    rd(32'h2020, 32'h5);
    btn[0] = 1'b0;
    idle(8);
    rd(32'h2020, 32'h4);
    rd(32'h2024, 32'h5);

    // W1C bit 0 on the same edge as a new btn[0] rise
    btn[0] = 1'b1;
    idle(5);
    rdwr(32'h2024, 32'h1, 32'h5);
    rd(32'h2024, 32'h5);
    rdwr(32'h2024, 32'h4, 32'h5);
    rd(32'h2024, 32'h1);
    idle(1);

    // Misses, ignored writes, byte offset
    cyc(1'b0, 32'h2030, 1'b1, 1'b0, 32'h0);
    check("miss_rvalid", 32'(bus.rvalid), 32'h0);
    check("miss_rdata", bus.rdata, 32'h0);
    wr(32'h2034, 32'hff);
    rd(32'h2024, 32'h1);
    wr(32'h2020, 32'hff);
    rd(32'h2020, 32'h5);
    wr(32'h2028, 32'hff);
    rd(32'h2028, 32'h0);
    rd(32'h2027, 32'h1);
    rd(32'h202c, 32'h0);
    idle(1);

    // Reset mid-debounce
    btn = '0;
    idle(10);
    rd(32'h2020, 32'h0);
    btn[1] = 1'b1;
    idle(4);
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    check("mid_rst_rvalid", 32'(bus.rvalid), 32'h0);
    idle(5);
    rd(32'h2020, 32'h0);
    rd(32'h2020, 32'h2);
    rd(32'h2024, 32'h2);
    idle(1);

`ifdef BTN_IRQ_EN
    wr(32'h2024, 32'hff);
    wr(32'h202c, 32'h2);
    rd(32'h202c, 32'h2);
    check("irq_idle", 32'(irq), 32'h0);
    btn[1] = 1'b0;
    idle(10);
    check("irq_fall", 32'(irq), 32'h0);
    btn[1] = 1'b1;
    idle(5);
    check("irq_early", 32'(irq), 32'h0);
    idle(1);
    check("irq_set", 32'(irq), 32'h1);
    wr(32'h2024, 32'h2);
    check("irq_clr", 32'(irq), 32'h0);
    btn[3] = 1'b1;
    idle(8);
    check("irq_masked", 32'(irq), 32'h0);
    rd(32'h2024, 32'h8);
    idle(1);
`endif

    idle(2);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
